// File: rtl/gray_decoder_if.sv
// Gray decoder stream interface: Gray words in, decoded binary words and
// step flags out.
interface gray_decoder_if #(
   parameter int N = 4
);
   // Handshake semantics (both directions): a word moves on a rising clock
   // edge where valid && ready. Once the producer raises valid, the word and
   // its flags hold steady until that edge. ready may depend combinationally
   // on the consumer's state but never on valid.
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_gray;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_bin;
   logic         out_first;
   logic         out_step_ok;
   logic         out_up;
   logic         out_down;

   // Upstream/downstream side (test driver or surrounding logic)
   modport master (
      output in_valid, in_gray, out_ready,
      input  in_ready, out_valid, out_bin, out_first, out_step_ok, out_up, out_down
   );

   // Decoder side
   modport slave (
      input  in_valid, in_gray, out_ready,
      output in_ready, out_valid, out_bin, out_first, out_step_ok, out_up, out_down
   );
endinterface

// File: rtl/gray_decoder.sv
// Gray-to-binary decoder with one-word output register, step checking
// (single-bit change, +1 / -1 direction) and a saturating step-error counter.
module gray_decoder #(
   parameter int N     = 4,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   gray_decoder_if.slave    bus,
   input  logic             clr_err,
   output logic [ERR_W-1:0] err_cnt
);
   localparam logic [N-1:0]     BIN_ONE = {{(N-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   logic [N-1:0] prev_gray;
   logic [N-1:0] prev_bin;
   logic         first_pending;
   logic [N-1:0] bin_c;
   logic [N-1:0] diff_c;
   logic         one_bit_c;
   logic         up_c;
   logic         down_c;
   logic         accept;
   logic         err_inc;

   // The output register frees up when empty or when its word leaves this cycle.
   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   // Decode: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      bin_c      = '0;
      bin_c[N-1] = bus.in_gray[N-1];
      for (int i = N - 2; i >= 0; i--) begin
         bin_c[i] = bin_c[i+1] ^ bus.in_gray[i];
      end
   end

   // Step classification against the previously accepted code.
   always_comb begin
      diff_c    = bus.in_gray ^ prev_gray;
      // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
      one_bit_c = (diff_c != '0) && ((diff_c & (diff_c - BIN_ONE)) == '0);
      // Modular +1/-1 compare; the N-bit arithmetic wraps for free.
      up_c      = !first_pending && one_bit_c && (bin_c == (prev_bin + BIN_ONE));
      down_c    = !first_pending && one_bit_c && (bin_c == (prev_bin - BIN_ONE));
      // A repeated identical code is also an error (distance 0).
      err_inc   = accept && !first_pending && !one_bit_c;
   end

   // Output register and history: load on acceptance, empty when drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid   <= 1'b0;
         bus.out_bin     <= '0;
         bus.out_first   <= 1'b0;
         bus.out_step_ok <= 1'b0;
         bus.out_up      <= 1'b0;
         bus.out_down    <= 1'b0;
         prev_gray       <= '0;
         prev_bin        <= '0;
         first_pending   <= 1'b1;
      end else if (accept) begin
         bus.out_valid   <= 1'b1;
         bus.out_bin     <= bin_c;
         bus.out_first   <= first_pending;
         bus.out_step_ok <= first_pending || one_bit_c;
         bus.out_up      <= up_c;
         bus.out_down    <= down_c;
         prev_gray       <= bus.in_gray;
         prev_bin        <= bin_c;
         first_pending   <= 1'b0;
      end else if (bus.out_valid && bus.out_ready) begin
         bus.out_valid   <= 1'b0;
      end
   end

   // Saturating step-error counter; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (clr_err) begin
         err_cnt <= '0;
      end else if (err_inc && (err_cnt != ERR_MAX)) begin
         err_cnt <= err_cnt + ERR_ONE;
      end
   end
endmodule

// File: tb/tb_gray_decoder.sv
// Bench for gray_decoder: two instances (8-bit and 2-bit error counters)
// share one stimulus stream; a behavioural model predicts every cycle.
module tb_gray_decoder;
   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic         clr_err;
   logic         in_valid;
   logic         out_ready;
   logic [N-1:0] in_gray;
   logic [7:0]   err_a;
   logic [1:0]   err_b;

   int total = 0;
   int bad   = 0;

   gray_decoder_if #(.N(N)) bus_a ();
   gray_decoder_if #(.N(N)) bus_b ();

   assign bus_a.in_valid  = in_valid;
   assign bus_a.in_gray   = in_gray;
   assign bus_a.out_ready = out_ready;
   assign bus_b.in_valid  = in_valid;
   assign bus_b.in_gray   = in_gray;
   assign bus_b.out_ready = out_ready;

   gray_decoder #(.N(N), .ERR_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .clr_err(clr_err), .err_cnt(err_a)
   );
   gray_decoder #(.N(N), .ERR_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .clr_err(clr_err), .err_cnt(err_b)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   bit m_valid, m_first, m_step, m_up, m_down, m_pend;
   int m_bin, m_prev_gray, m_prev_bin, m_err_a, m_err_b;

   // Binary value whose Gray code is g, found by search over all codes.
   function automatic int g2b(input int g);
      for (int b = 0; b < (1 << N); b++) begin
         if ((b ^ (b >> 1)) == g) return b;
      end
      return -1;
   endfunction

   function automatic int b2g(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_first = 0; m_step = 0; m_up = 0; m_down = 0;
      m_pend = 1; m_bin = 0; m_prev_gray = 0; m_prev_bin = 0;
      m_err_a = 0; m_err_b = 0;
   endtask

   // Compare on the falling edge, then predict the next rising edge.
   always @(negedge clk) begin
      bit acc, step, e_inc;
      int b;
      if (!rst_n) begin
         model_reset();
         chk("rst_out_valid", int'(bus_a.out_valid), 0);
         chk("rst_out_bin", int'(bus_a.out_bin), 0);
         chk("rst_flags", int'({bus_a.out_first, bus_a.out_step_ok, bus_a.out_up, bus_a.out_down}), 0);
         chk("rst_err_a", int'(err_a), 0);
         chk("rst_in_ready", int'(bus_a.in_ready), 1);
      end else begin
         chk("cmp_in_ready", int'(bus_a.in_ready), int'(!m_valid || out_ready));
         chk("cmp_out_valid", int'(bus_a.out_valid), int'(m_valid));
         chk("cmp_out_valid_b", int'(bus_b.out_valid), int'(m_valid));
         if (m_valid) begin
            chk("cmp_out_bin", int'(bus_a.out_bin), m_bin);
            chk("cmp_out_first", int'(bus_a.out_first), int'(m_first));
            chk("cmp_out_step_ok", int'(bus_a.out_step_ok), int'(m_step));
            chk("cmp_out_up", int'(bus_a.out_up), int'(m_up));
            chk("cmp_out_down", int'(bus_a.out_down), int'(m_down));
            chk("cmp_out_bin_b", int'(bus_b.out_bin), m_bin);
         end
         chk("cmp_err_a", int'(err_a), m_err_a);
         chk("cmp_err_b", int'(err_b), m_err_b);

         acc   = in_valid && (!m_valid || out_ready);
         step  = ($countones(int'(in_gray) ^ m_prev_gray) == 1);
         e_inc = acc && !m_pend && !step;
         if (clr_err) begin
            m_err_a = 0;
            m_err_b = 0;
         end else if (e_inc) begin
            m_err_a = (m_err_a < 255) ? m_err_a + 1 : 255;
            m_err_b = (m_err_b < 3) ? m_err_b + 1 : 3;
         end
         if (acc) begin
            b = g2b(int'(in_gray));
            m_valid = 1;
            m_bin   = b;
            if (m_pend) begin
               m_first = 1; m_step = 1; m_up = 0; m_down = 0;
            end else begin
               m_first = 0;
               m_step  = step;
               m_up    = step && (b == (m_prev_bin + 1) % (1 << N));
               m_down  = step && (b == (m_prev_bin + (1 << N) - 1) % (1 << N));
            end
            m_prev_gray = int'(in_gray);
            m_prev_bin  = b;
            m_pend      = 0;
         end else if (m_valid && out_ready) begin
            m_valid = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Present one code for one cycle (out_ready assumed 1), land at edge + 1.
   task automatic send(input logic [N-1:0] g);
      in_valid = 1'b1;
      in_gray  = g;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int nb;
      rst_n = 1'b0; clr_err = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_gray = '0;
      repeat (3) tick();
      chk("reset_in_ready", int'(bus_a.in_ready), 1);
      chk("reset_out_valid", int'(bus_a.out_valid), 0);
      rst_n = 1'b1;
      tick();

      // Full sweep 0..15
      for (int i = 0; i < 16; i++) begin
         send(4'(b2g(i)));
         chk("sweep_bin", int'(bus_a.out_bin), i);
         chk("sweep_first", int'(bus_a.out_first), (i == 0) ? 1 : 0);
         if (i != 0) chk("sweep_up", int'(bus_a.out_up), 1);
      end
      chk("sweep_err", int'(err_a), 0);

      // Wrap up and down step
      send(4'b0000);
      chk("wrap_bin", int'(bus_a.out_bin), 0);
      chk("wrap_up", int'(bus_a.out_up), 1);
      send(4'b0001);
      send(4'b0011);
      send(4'b0001);
      chk("down_bin", int'(bus_a.out_bin), 1);
      chk("down_flag", int'(bus_a.out_down), 1);

      // Backpressure
      in_valid = 1'b1; in_gray = 4'b0011;
      tick();
      chk("bp_first_bin", int'(bus_a.out_bin), 2);
      out_ready = 1'b0; in_gray = 4'b0010;
      #1;
      chk("bp_in_ready", int'(bus_a.in_ready), 0);
      repeat (3) begin
         tick();
         chk("bp_hold_ready", int'(bus_a.in_ready), 0);
         chk("bp_hold_bin", int'(bus_a.out_bin), 2);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release_bin", int'(bus_a.out_bin), 3);
      in_gray = 4'b0110;
      tick();
      chk("bp_next_bin", int'(bus_a.out_bin), 4);
      in_valid = 1'b0;
      tick();

      // Step errors, clear, saturation
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      send(4'b0000);
      send(4'b0011);
      chk("err_step1", int'(bus_a.out_step_ok), 0);
      send(4'b0011);
      chk("err_step2", int'(bus_a.out_step_ok), 0);
      chk("err_cnt2", int'(err_a), 2);
      clr_err = 1'b1;
      send(4'b0011);
      clr_err = 1'b0;
      chk("err_clr_a", int'(err_a), 0);
      chk("err_clr_b", int'(err_b), 0);
      repeat (5) send(4'b0011);
      chk("sat_err_a", int'(err_a), 5);
      chk("sat_err_b", int'(err_b), 3);

      // Reset mid-stream
      send(4'b0001);
      chk("mid_valid_before", int'(bus_a.out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_async_valid", int'(bus_a.out_valid), 0);
      tick();
      rst_n = 1'b1;
      send(4'b0110);
      chk("post_rst_bin", int'(bus_a.out_bin), 4);
      chk("post_rst_first", int'(bus_a.out_first), 1);
      chk("post_rst_err", int'(err_a), 0);

      // Random traffic: mostly +/-1 steps, some arbitrary codes
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         clr_err   = ($urandom_range(0, 24) == 0);
         case ($urandom_range(0, 3))
            0: nb = (m_prev_bin + 1) % 16;
            1: nb = (m_prev_bin + 15) % 16;
            2: nb = m_prev_bin;
            default: nb = int'($urandom_range(0, 15));
         endcase
         in_gray = 4'(b2g(nb));
         tick();
      end
      in_valid = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
